// File: rtl/axis_pixels_frame.sv
// axis_pixels_frame: cuts a DMA word stream into pixel-pipe frames.
// Each frame starts with a cfg handshake that gives the frame length in words.
// The block forwards the matching number of beats, tags the final beat with a
// partial keep and last, and holds the output in a 2-entry skid buffer.
// Optional framing check: define AXIS_PIXELS_FRAME_ERR_EN to compare s_last
// against the count-derived final beat. err is sticky until reset.
//
// Handshake rule (all channels): a transfer happens on a rising clock edge
// where valid and ready are both 1. Once asserted, valid and the payload
// stay unchanged until that edge.
module axis_pixels_frame #(
  parameter int WORD_WIDTH = 8,
  parameter int LANES      = 8,
  parameter int BITS_WORDS = 24
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  input  logic                        cfg_valid,
  output logic                        cfg_ready,
  input  logic [BITS_WORDS-1:0]       cfg_words,
  input  logic                        s_valid,
  output logic                        s_ready,
  input  logic [LANES*WORD_WIDTH-1:0] s_data,
  input  logic                        s_last,
  output logic                        m_valid,
  input  logic                        m_ready,
  output logic [LANES*WORD_WIDTH-1:0] m_data,
  output logic [LANES-1:0]            m_keep,
  output logic                        m_last,
  output logic                        busy,
  output logic                        err,
  output logic                        dbg_state_o
);

  localparam int DW = LANES * WORD_WIDTH;
  // Each buffer slot holds {last, keep, data}.
  localparam int SW = DW + LANES + 1;
  localparam logic [BITS_WORDS-1:0] LANES_W = BITS_WORDS'(LANES);
  localparam logic [BITS_WORDS-1:0] ONE_W   = BITS_WORDS'(1);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t                state_q, state_d;
  logic [BITS_WORDS-1:0] beats_q, beats_d;
  logic [LANES-1:0]      last_keep_q, last_keep_d;
  logic [SW-1:0]         slot0_q, slot0_d;
  logic [SW-1:0]         slot1_q, slot1_d;
  logic [1:0]            count_q, count_d;
  logic                  s_ready_q, s_ready_d;

  logic [BITS_WORDS-1:0] cfg_rem;
  logic [BITS_WORDS-1:0] cfg_beats;
  logic [LANES-1:0]      cfg_keep;
  logic                  push, pop, final_beat;
  logic [SW-1:0]         in_slot;

  // Decode the frame length into a beat count and a final-beat keep mask.
  // Dividing first means the all-ones word count cannot overflow.
  always_comb begin
    cfg_rem   = cfg_words % LANES_W;
    cfg_beats = (cfg_words / LANES_W) + {{(BITS_WORDS-1){1'b0}}, (cfg_rem != '0)};
    cfg_keep  = '0;
    for (int i = 0; i < LANES; i++) begin
      cfg_keep[i] = (cfg_rem == '0) || (BITS_WORDS'(i) < cfg_rem);
    end
  end

  assign cfg_ready  = aresetn && (state_q == IDLE);
  assign push       = s_valid && s_ready_q;
  assign pop        = (count_q != 2'd0) && m_ready;
  assign final_beat = (beats_q == ONE_W);
  assign in_slot    = {final_beat, (final_beat ? last_keep_q : {LANES{1'b1}}), s_data};

  // Next-state logic for the frame FSM, beat counter and skid buffer.
  always_comb begin
    state_d     = state_q;
    beats_d     = beats_q;
    last_keep_d = last_keep_q;
    slot0_d     = slot0_q;
    slot1_d     = slot1_q;
    count_d     = count_q;

    case (state_q)
      IDLE: begin
        if (cfg_valid && (cfg_words != '0)) begin
          beats_d     = cfg_beats;
          last_keep_d = cfg_keep;
          state_d     = RUN;
        end
      end
      RUN: begin
        if (push) begin
          beats_d = beats_q - ONE_W;
          if (final_beat) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // slot0 is the output register; slot1 only fills when the sink stalls.
    case (count_q)
      2'd0: begin
        if (push) begin
          slot0_d = in_slot;
          count_d = 2'd1;
        end
      end
      2'd1: begin
        if (push && pop) begin
          slot0_d = in_slot;
        end else if (push) begin
          slot1_d = in_slot;
          count_d = 2'd2;
        end else if (pop) begin
          count_d = 2'd0;
        end
      end
      2'd2: begin
        if (pop) begin
          slot0_d = slot1_q;
          count_d = 2'd1;
        end
      end
      default: count_d = 2'd0;
    endcase

    // s_ready is registered, so it looks at next-cycle state and occupancy.
    s_ready_d = (state_d == RUN) && (count_d != 2'd2);
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q     <= IDLE;
      beats_q     <= '0;
      last_keep_q <= '0;
      slot0_q     <= '0;
      slot1_q     <= '0;
      count_q     <= 2'd0;
      s_ready_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      beats_q     <= beats_d;
      last_keep_q <= last_keep_d;
      slot0_q     <= slot0_d;
      slot1_q     <= slot1_d;
      count_q     <= count_d;
      s_ready_q   <= s_ready_d;
    end
  end

`ifdef AXIS_PIXELS_FRAME_ERR_EN
  logic err_q;

  // Sticky framing error: s_last disagrees with the count on an accepted beat.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      err_q <= 1'b0;
    end else if (push && (s_last != final_beat)) begin
      err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  logic unused_s_last;
  assign unused_s_last = s_last;
  assign err = 1'b0;
`endif

  assign s_ready     = s_ready_q;
  assign m_valid     = (count_q != 2'd0);
  assign m_data      = slot0_q[DW-1:0];
  assign m_keep      = slot0_q[DW+LANES-1:DW];
  assign m_last      = slot0_q[SW-1];
  assign busy        = (state_q == RUN) || (count_q != 2'd0);
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_axis_pixels_frame.sv
// Testbench for axis_pixels_frame: drives frames through the cfg and s_*
// channels and compares m_* against an expected-beat queue. It also checks
// that a stalled output holds stable and that s_ready drops when 2 beats are
// held. Follows AXIS_PIXELS_FRAME_ERR_EN for the expected err value.
module tb_axis_pixels_frame;

  localparam int WW = 8;
  localparam int L  = 8;
  localparam int BW = 24;
  localparam int DW = WW * L;
  localparam int SW = DW + L + 1;

  logic          aclk;
  logic          aresetn;
  logic          cfg_valid;
  logic          cfg_ready;
  logic [BW-1:0] cfg_words;
  logic          s_valid;
  logic          s_ready;
  logic [DW-1:0] s_data;
  logic          s_last;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
  logic [L-1:0]  m_keep;
  logic          m_last;
  logic          busy;
  logic          err;
  logic          dbg_state;

  axis_pixels_frame #(.WORD_WIDTH(WW), .LANES(L), .BITS_WORDS(BW)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_words(cfg_words),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_keep(m_keep),
    .m_last(m_last), .busy(busy), .err(err), .dbg_state_o(dbg_state)
  );

  // Clock and reset-time defaults.
  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  int total = 0;
  int bad   = 0;
  int mr_mode = 0;   // 0: m_ready=1, 1: random, 2: m_ready=0
  int occ = 0;
  logic [SW-1:0] exp_q[$];

`ifdef AXIS_PIXELS_FRAME_ERR_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Sink backpressure driver.
  initial begin
    m_ready = 1'b1;
    forever begin
      @(posedge aclk);
      #1;
      case (mr_mode)
        0:       m_ready = 1'b1;
        1:       m_ready = 1'($urandom_range(0, 1));
        default: m_ready = 1'b0;
      endcase
    end
  end

  // Output monitor / scoreboard, sampling on the falling edge.
  initial begin
    logic          hold;
    logic [SW-1:0] held;
    logic [SW-1:0] e;
    hold = 1'b0;
    held = '0;
    forever begin
      @(negedge aclk);
      if (!aresetn) begin
        occ  = 0;
        hold = 1'b0;
      end else begin
        if (hold) begin
          check("hold_valid", m_valid, 1'b1);
          check("hold_payload", {m_last, m_keep, m_data}, held);
        end
        if (occ == 2) check("full_s_ready", s_ready, 1'b0);
        if (m_valid && m_ready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_beat", {m_last, m_keep, m_data}, 0);
          end else begin
            e = exp_q.pop_front();
            check("beat", {m_last, m_keep, m_data}, e);
          end
          occ--;
        end
        if (s_valid && s_ready) occ++;
        hold = m_valid && !m_ready;
        held = {m_last, m_keep, m_data};
      end
    end
  end

  task automatic do_cfg(input logic [BW-1:0] w, output int waits);
    logic hs;
    hs = 1'b0;
    waits = 0;
    cfg_valid = 1'b1;
    cfg_words = w;
    for (int i = 0; i < 200; i++) begin
      @(negedge aclk);
      hs = cfg_ready;
      @(posedge aclk);
      #1;
      if (hs) break;
      waits++;
    end
    if (!hs) check("cfg_timeout", 0, 1);
    cfg_valid = 1'b0;
  endtask

  // Drives up to nmax beats of a w-word frame; bad_idx flips s_last on that beat.
  task automatic do_beats(input int w, input int bad_idx, input int nmax, output int stalls);
    int n;
    int rem;
    logic hs;
    logic [L-1:0] lk;
    logic [L-1:0] k;
    n = (w + L - 1) / L;
    rem = w % L;
    lk = (rem == 0) ? {L{1'b1}} : L'((1 << rem) - 1);
    stalls = 0;
    for (int i = 0; i < n && i < nmax; i++) begin
      s_valid = 1'b1;
      s_data  = {$urandom, $urandom};
      s_last  = (i == n - 1) ^ (i == bad_idx);
      k = (i == n - 1) ? lk : {L{1'b1}};
      hs = 1'b0;
      for (int c = 0; c < 500; c++) begin
        @(negedge aclk);
        hs = s_ready;
        if (hs) exp_q.push_back({(i == n - 1), k, s_data});
        @(posedge aclk);
        #1;
        if (hs) break;
        stalls++;
      end
      if (!hs) begin
        check("beat_timeout", 0, 1);
        break;
      end
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 300; i++) begin
      @(negedge aclk);
      if (exp_q.size() == 0 && !m_valid) break;
    end
    check(tag, exp_q.size(), 0);
    check({tag, "_busy"}, busy, 1'b0);
    @(posedge aclk);
    #1;
  endtask

  // Main sequence.
  initial begin
    int waits;
    int stalls;
    aresetn   = 1'b0;
    cfg_valid = 1'b0;
    cfg_words = '0;
    s_valid   = 1'b0;
    s_data    = '0;
    s_last    = 1'b0;

    repeat (3) @(posedge aclk);
    @(negedge aclk);
    check("rst_m_valid", m_valid, 1'b0);
    check("rst_m_data", m_data, 0);
    check("rst_m_keep", m_keep, 0);
    check("rst_m_last", m_last, 1'b0);
    check("rst_s_ready", s_ready, 1'b0);
    check("rst_cfg_ready", cfg_ready, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_err", err, 1'b0);
    @(posedge aclk);
    #1;
    aresetn = 1'b1;
    @(negedge aclk);
    check("cfg_ready_after_rst", cfg_ready, 1'b1);
    @(posedge aclk);
    #1;

    // 20 words: FF, FF, 0F+last, no input stalls.
    do_cfg(24'd20, waits);
    do_beats(20, -1, 100, stalls);
    check("w20_stalls", stalls, 0);
    drain("w20_drain");

    // 16 words: FF, FF+last.
    do_cfg(24'd16, waits);
    do_beats(16, -1, 100, stalls);
    drain("w16_drain");

    // Zero-length cfg is consumed without output.
    do_cfg(24'd0, waits);
    check("w0_waits", waits, 0);
    repeat (3) begin
      @(negedge aclk);
      check("w0_cfg_ready", cfg_ready, 1'b1);
      check("w0_m_valid", m_valid, 1'b0);
      check("w0_busy", busy, 1'b0);
    end
    @(posedge aclk);
    #1;

    // 80 words under random backpressure.
    mr_mode = 1;
    do_cfg(24'd80, waits);
    do_beats(80, -1, 100, stalls);
    drain("w80_drain");
    mr_mode = 0;

    // Back-to-back frames: the second cfg must be taken without waiting.
    do_cfg(24'd8, waits);
    do_beats(8, -1, 100, stalls);
    do_cfg(24'd9, waits);
    check("b2b_cfg_waits", waits, 0);
    do_beats(9, -1, 100, stalls);
    check("b2b_stalls", stalls, 0);
    drain("b2b_drain");

    // Framing error: s_last on beat 2 of 3; output still follows the count.
    do_cfg(24'd24, waits);
    do_beats(24, 1, 100, stalls);
    check("err_after_frame", err, EXP_ERR);
    drain("err_drain");
    check("err_sticky", err, EXP_ERR);

    // Mid-frame reset after beat 1 of 3, with the sink stalled.
    mr_mode = 2;
    do_cfg(24'd24, waits);
    do_beats(24, -1, 1, stalls);
    aresetn = 1'b0;
    @(posedge aclk);
    #1;
    aresetn = 1'b1;
    exp_q.delete();
    mr_mode = 0;
    @(negedge aclk);
    check("mrst_m_valid", m_valid, 1'b0);
    check("mrst_busy", busy, 1'b0);
    check("mrst_cfg_ready", cfg_ready, 1'b1);
    check("mrst_err", err, 1'b0);
    @(posedge aclk);
    #1;
    do_cfg(24'd8, waits);
    do_beats(8, -1, 100, stalls);
    drain("post_rst_drain");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
